// File: rtl/date_set_ctrl.sv
// Front-panel date-set controller: debounced MODE/INC buttons walk a year/month/day
// edit sequence on a shadow date, then load it into the free-running counter chain.
module date_set_ctrl #(
  parameter int unsigned DB_CYCLES = 20000,
  parameter int unsigned BLINK_EXP = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [7:0] cur_year,
  input  logic [7:0] cur_month,
  input  logic [7:0] cur_day,
  output logic       run_en,
  output logic       load,
  output logic [7:0] ld_year,
  output logic [7:0] ld_month,
  output logic [7:0] ld_day,
  output logic [1:0] field,
  output logic       blink_on
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_Y = 2'b01,
    SET_M = 2'b10,
    SET_D = 2'b11
  } state_t;

  state_t               state, state_nxt;
  logic [1:0]           sync1, sync2, db, db_q;
  logic [1:0][CW-1:0]   db_cnt;
  logic                 press_mode_c, press_inc_c;
  logic [BLINK_EXP-1:0] blink_cnt, blink_nxt_c;
  logic [7:0]           year_nxt, month_nxt, day_nxt, max_day_c;
  logic                 load_nxt;

  // Leap test straight on BCD: even tens need ones 0/4/8, odd tens need ones 2/6
  function automatic logic is_leap(input logic [7:0] y);
    logic [3:0] o;
    o = y[3:0];
    if (y[4]) return (o == 4'h2) || (o == 4'h6);
    return (o == 4'h0) || (o == 4'h4) || (o == 4'h8);
  endfunction

  function automatic logic [7:0] days_in(input logic [7:0] y, input logic [7:0] m);
    case (m)
      8'h02:                      return is_leap(y) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  // BCD +1 with decimal carry; anything at or above hi (including non-BCD) wraps to lo
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (v >= hi) return lo;
    if (v[3:0] >= 4'h9) return {v[7:4] + 4'h1, 4'h0};
    return {v[7:4], v[3:0] + 4'h1};
  endfunction

  // Synchronize and debounce both buttons; index 0 = MODE, 1 = INC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_q   <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= {btn_inc, btn_mode};
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
            db[i]     <= ~db[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press_mode_c = db[0] & ~db_q[0];
  assign press_inc_c  = db[1] & ~db_q[1];
  assign blink_nxt_c  = blink_cnt + BLINK_EXP'(1);
  assign max_day_c    = days_in(ld_year, ld_month);

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      run_en    <= 1'b1;
      field     <= 2'b00;
      load      <= 1'b0;
      ld_year   <= 8'h21;
      ld_month  <= 8'h01;
      ld_day    <= 8'h01;
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else begin
      state     <= state_nxt;
      run_en    <= (state_nxt == RUN);
      field     <= state_nxt;
      load      <= load_nxt;
      ld_year   <= year_nxt;
      ld_month  <= month_nxt;
      ld_day    <= day_nxt;
      blink_cnt <= blink_nxt_c;
      blink_on  <= blink_nxt_c[BLINK_EXP-1] & (state_nxt != RUN);
    end
  end

  // Next state: only MODE presses move the sequence
  always_comb begin
    state_nxt = state;
    if (press_mode_c) begin
      case (state)
        RUN:     state_nxt = SET_Y;
        SET_Y:   state_nxt = SET_M;
        SET_M:   state_nxt = SET_D;
        default: state_nxt = RUN;
      endcase
    end
  end

  // Shadow-register and load-strobe updates; MODE has priority over INC
  always_comb begin
    year_nxt  = ld_year;
    month_nxt = ld_month;
    day_nxt   = ld_day;
    load_nxt  = 1'b0;
    if (press_mode_c) begin
      case (state)
        RUN: begin
          year_nxt  = cur_year;
          month_nxt = cur_month;
          day_nxt   = cur_day;
        end
        SET_M:   if (ld_day > max_day_c) day_nxt = max_day_c;
        SET_D:   load_nxt = 1'b1;
        default: ;
      endcase
    end else if (press_inc_c) begin
      case (state)
        SET_Y:   year_nxt  = bcd_inc(ld_year, 8'h21, 8'h48);
        SET_M:   month_nxt = bcd_inc(ld_month, 8'h01, 8'h12);
        SET_D:   day_nxt   = bcd_inc(ld_day, 8'h01, max_day_c);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_date_set_ctrl.sv
// Scoreboard bench for date_set_ctrl: directed scenarios plus random button traffic
// checked against an integer-arithmetic calendar model.
module tb_date_set_ctrl;

  localparam int unsigned DB  = 4;
  localparam int unsigned BE  = 4;
  localparam int          LAT = DB + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0;
  logic [7:0] cur_year = 8'h21, cur_month = 8'h01, cur_day = 8'h01;
  logic       run_en, load, blink_on;
  logic [7:0] ld_year, ld_month, ld_day;
  logic [1:0] field;

  date_set_ctrl #(.DB_CYCLES(DB), .BLINK_EXP(BE)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
    .run_en(run_en), .load(load), .ld_year(ld_year), .ld_month(ld_month),
    .ld_day(ld_day), .field(field), .blink_on(blink_on)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         fld;
    bit         ld;
    logic [7:0] y, m, d;
    int         at;
  } exp_t;
  exp_t q[$];

  // Reference model: plain integers
  int m_st = 0, m_y = 21, m_m = 1, m_d = 1;
  int c_y = 21, c_m = 1, c_d = 1;

  function automatic int mdays(input int y, input int m);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic push(input int at, input bit ld);
    exp_t e;
    e.fld = m_st; e.ld = ld; e.y = bcd(m_y); e.m = bcd(m_m); e.d = bcd(m_d); e.at = at;
    q.push_back(e);
  endtask

  task automatic wait_edge(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_cur(input int y, input int m, input int d);
    c_y = y; c_m = m; c_d = d;
    cur_year = bcd(y); cur_month = bcd(m); cur_day = bcd(d);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bounce selected buttons (even count of 2-cycle toggles), final rise, hold, release
  task automatic press(input bit pm, input bit pi, input int bounces);
    int at;
    for (int k = 0; k < bounces; k++) begin
      if (pm) btn_mode = ~btn_mode;
      if (pi) btn_inc = ~btn_inc;
      wait_edge(2);
    end
    if (pm) btn_mode = 1'b1;
    if (pi) btn_inc = 1'b1;
    at = cyc + LAT;
    if (pm) begin
      case (m_st)
        0: begin m_y = c_y; m_m = c_m; m_d = c_d; m_st = 1; push(at, 1'b0); end
        1: begin m_st = 2; push(at, 1'b0); end
        2: begin
          m_st = 3;
          if (m_d > mdays(m_y, m_m)) m_d = mdays(m_y, m_m);
          push(at, 1'b0);
        end
        default: begin m_st = 0; push(at, 1'b1); end
      endcase
    end else if (pi && m_st != 0) begin
      case (m_st)
        1:       m_y = (m_y >= 48) ? 21 : m_y + 1;
        2:       m_m = (m_m >= 12) ? 1 : m_m + 1;
        default: m_d = (m_d >= mdays(m_y, m_m)) ? 1 : m_d + 1;
      endcase
      push(at, 1'b0);
    end
    wait_edge(12);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    wait_edge(10);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_run_en"}, 8'(run_en), 8'h01);
    check({tag, "_field"},  8'(field),  8'h00);
    check({tag, "_load"},   8'(load),   8'h00);
    check({tag, "_year"},   ld_year,    8'h21);
    check({tag, "_month"},  ld_month,   8'h01);
    check({tag, "_day"},    ld_day,     8'h01);
  endtask

  // Monitor: any change of the visible date/field (or a load strobe) pops one expectation
  initial begin
    logic [1:0] p_f;
    logic [7:0] p_y, p_m, p_d;
    int         exp_field;
    bit         exp_blink;
    exp_t       e;
    p_f = 2'b00; p_y = 8'h21; p_m = 8'h01; p_d = 8'h01; exp_field = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        checks++;
        if (load !== 1'b0) begin
          errors++;
          $display("FAIL load_in_reset: load=%b expected 0", load);
        end
        exp_field = 0;
      end else begin
        if (load === 1'b1 || field !== p_f || ld_year !== p_y || ld_month !== p_m ||
            ld_day !== p_d) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: cyc=%0d field=%0d load=%b ld=%h/%h/%h",
                     cyc, field, load, ld_year, ld_month, ld_day);
          end else begin
            e = q.pop_front();
            exp_field = e.fld;
            if (field !== 2'(e.fld) || run_en !== (e.fld == 0) || load !== e.ld ||
                ld_year !== e.y || ld_month !== e.m || ld_day !== e.d || cyc != e.at) begin
              errors++;
              $display("FAIL event: got cyc=%0d field=%0d run_en=%b load=%b ld=%h/%h/%h expected cyc=%0d field=%0d load=%b ld=%h/%h/%h",
                       cyc, field, run_en, load, ld_year, ld_month, ld_day,
                       e.at, e.fld, e.ld, e.y, e.m, e.d);
            end
          end
        end
        checks++;
        exp_blink = (((cyc >> (BE - 1)) & 1) == 1) && (exp_field != 0);
        if (blink_on !== exp_blink) begin
          errors++;
          $display("FAIL blink: cyc=%0d got %b expected %b", cyc, blink_on, exp_blink);
        end
      end
      p_f = field; p_y = ld_year; p_m = ld_month; p_d = ld_day;
    end
  end

  initial begin
    int r;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_vals("reset");
    wait_edge(16);

    // Bounced entry capturing 23/11/30, then edit to 24/02 and clamp the day
    set_cur(23, 11, 30);
    press(1'b1, 1'b0, 10);
    press(1'b0, 1'b1, 0);
    press(1'b1, 1'b0, 0);
    repeat (3) press(1'b0, 1'b1, 2);
    press(1'b1, 1'b0, 0);
    press(1'b1, 1'b0, 0);

    // Year and month wraps
    set_cur(48, 12, 28);
    press(1'b1, 1'b0, 0);
    press(1'b0, 1'b1, 0);
    press(1'b1, 1'b0, 0);
    press(1'b0, 1'b1, 0);
    press(1'b1, 1'b0, 0);
    press(1'b1, 1'b0, 0);

    // Day wrap at end of a non-leap February
    set_cur(25, 2, 28);
    repeat (3) press(1'b1, 1'b0, 0);
    press(1'b0, 1'b1, 0);
    press(1'b1, 1'b0, 0);

    // Simultaneous MODE and INC: MODE wins
    set_cur(30, 5, 10);
    press(1'b1, 1'b0, 0);
    press(1'b1, 1'b1, 0);
    press(1'b1, 1'b0, 0);
    press(1'b1, 1'b0, 0);

    // Reset mid-edit drops everything with no load strobe
    set_cur(33, 7, 15);
    press(1'b1, 1'b0, 0);
    press(1'b1, 1'b0, 0);
    press(1'b0, 1'b1, 0);
    reset = 1'b0;
    #1 check_reset_vals("midreset");
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    m_st = 0; m_y = 21; m_m = 1; m_d = 1;
    wait_edge(8);

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 9));
      if (m_st == 0) begin
        if (r < 2) press(1'b0, 1'b1, 2 * int'($urandom_range(0, 3)));
        else begin
          set_cur(int'($urandom_range(21, 48)), int'($urandom_range(1, 12)),
                  int'($urandom_range(1, 31)));
          press(1'b1, 1'b0, 2 * int'($urandom_range(0, 3)));
        end
      end else if (r < 3) press(1'b1, 1'b0, 2 * int'($urandom_range(0, 3)));
      else if (r == 9)    press(1'b1, 1'b1, 0);
      else                press(1'b0, 1'b1, 2 * int'($urandom_range(0, 3)));
    end
    while (m_st != 0) press(1'b1, 1'b0, 0);

    for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
